// File: rtl/ahb_slave_resp_mux_if.sv
// rtl/ahb_slave_resp_mux_if.sv - AHB-Lite data-phase response mux bus bundle
`timescale 1ns/1ps
interface ahb_slave_resp_mux_if #(
  parameter int NSLV = 16
);
  logic [NSLV-1:0]    HSEL_i;
  logic [1:0]         HTRANS_i;
  logic [NSLV*32-1:0] HRDATA_s_i;
  logic [NSLV-1:0]    HREADYOUT_s_i;
  logic [NSLV-1:0]    HRESP_s_i;
  logic [31:0]        HRDATA_o;
  logic               HREADY_o;
  logic               HRESP_o;

  modport slave (
    input  HSEL_i, HTRANS_i, HRDATA_s_i, HREADYOUT_s_i, HRESP_s_i,
    output HRDATA_o, HREADY_o, HRESP_o
  );

  modport master (
    output HSEL_i, HTRANS_i, HRDATA_s_i, HREADYOUT_s_i, HRESP_s_i,
    input  HRDATA_o, HREADY_o, HRESP_o
  );
endinterface

// File: rtl/ahb_slave_resp_mux.sv
// rtl/ahb_slave_resp_mux.sv - AHB-Lite data-phase response mux with built-in ERROR default slave
`timescale 1ns/1ps
module ahb_slave_resp_mux #(
  parameter int NSLV      = 16,
  parameter int DUMMY_IDX = 15,
  parameter int CNT_W     = 16
) (
  input  logic                   HCLK,
  input  logic                   HRST_N,
  ahb_slave_resp_mux_if.slave    bus,
  output logic [CNT_W-1:0]       ERR_CNT_o
);

  localparam int IDX_W = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam logic [IDX_W-1:0] DUMMY_SEL = IDX_W'(DUMMY_IDX);

  localparam logic [1:0] D_IDLE = 2'd0;
  localparam logic [1:0] D_ERR1 = 2'd1;
  localparam logic [1:0] D_ERR2 = 2'd2;

  logic [IDX_W-1:0] sel_q, sel_d;
  logic [1:0]       state_q, state_d;
  logic             is_dummy;
  logic             dummy_req;
  logic             hready, hresp;
  logic [31:0]      hrdata;
  logic             unused_htrans0;

  assign unused_htrans0 = bus.HTRANS_i[0];

  // Downward scan so the lowest asserted select bit is the one that sticks.
  always_comb begin
    sel_d = DUMMY_SEL;
    for (int k = NSLV - 1; k >= 0; k--) begin
      if (bus.HSEL_i[k]) sel_d = IDX_W'(k);
    end
  end

  assign is_dummy = (sel_q == DUMMY_SEL);

  always_comb begin
    hready = 1'b1;
    hresp  = 1'b0;
    hrdata = '0;
    if (is_dummy) begin
      hready = (state_q != D_ERR1);
      hresp  = (state_q != D_IDLE);
    end else begin
      hready = bus.HREADYOUT_s_i[sel_q];
      hresp  = bus.HRESP_s_i[sel_q];
      hrdata = bus.HRDATA_s_i[32*sel_q +: 32];
    end
  end

  assign bus.HREADY_o = hready;
  assign bus.HRESP_o  = hresp;
  assign bus.HRDATA_o = hrdata;

  assign dummy_req = hready & (sel_d == DUMMY_SEL) & bus.HTRANS_i[1];

  always_comb begin
    state_d = D_IDLE;
    case (state_q)
      D_IDLE:  state_d = dummy_req ? D_ERR1 : D_IDLE;
      D_ERR1:  state_d = D_ERR2;
      D_ERR2:  state_d = dummy_req ? D_ERR1 : D_IDLE;
      default: state_d = D_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRST_N) begin
    if (!HRST_N) begin
      sel_q     <= DUMMY_SEL;
      state_q   <= D_IDLE;
      ERR_CNT_o <= '0;
    end else begin
      if (hready) sel_q <= sel_d;
      state_q <= state_d;
      // Each ERR1 always advances to ERR2, so this counts one per ERROR response.
      if (state_q == D_ERR1 && ERR_CNT_o != {CNT_W{1'b1}}) begin
        ERR_CNT_o <= ERR_CNT_o + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ahb_slave_resp_mux.sv
// tb/tb_ahb_slave_resp_mux.sv - scoreboard bench for ahb_slave_resp_mux
`timescale 1ns/1ps
module tb_ahb_slave_resp_mux;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] NONSEQ = 2'b10;

  logic        HCLK;
  logic        HRST_N;
  logic [15:0] err_cnt;
  logic [1:0]  err_cnt2;

  ahb_slave_resp_mux_if #(.NSLV(16)) bus ();
  ahb_slave_resp_mux_if #(.NSLV(16)) bus2 ();

  ahb_slave_resp_mux #(.NSLV(16), .DUMMY_IDX(15), .CNT_W(16)) dut (
    .HCLK(HCLK), .HRST_N(HRST_N), .bus(bus.slave), .ERR_CNT_o(err_cnt)
  );

  ahb_slave_resp_mux #(.NSLV(16), .DUMMY_IDX(15), .CNT_W(2)) dut2 (
    .HCLK(HCLK), .HRST_N(HRST_N), .bus(bus2.slave), .ERR_CNT_o(err_cnt2)
  );

  assign bus2.HSEL_i        = bus.HSEL_i;
  assign bus2.HTRANS_i      = bus.HTRANS_i;
  assign bus2.HRDATA_s_i    = bus.HRDATA_s_i;
  assign bus2.HREADYOUT_s_i = bus.HREADYOUT_s_i;
  assign bus2.HRESP_s_i     = bus.HRESP_s_i;

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  typedef struct {
    string       tag;
    logic [33:0] v;
  } exp_t;

  exp_t sb[$];
  int   n_run  = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input logic rdy, input logic resp, input logic [31:0] data);
    exp_t e;
    e.tag = tag;
    e.v   = {rdy, resp, data};
    sb.push_back(e);
  endtask

  task automatic drive(input logic [15:0] sel, input logic [1:0] trans);
    bus.HSEL_i   = sel;
    bus.HTRANS_i = trans;
  endtask

  task automatic next_cyc();
    @(posedge HCLK);
    #1;
  endtask

  // Data-phase monitor: one expected beat per clock while the scoreboard holds entries.
  always @(negedge HCLK) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk(e.tag, 64'({bus.HREADY_o, bus.HRESP_o, bus.HRDATA_o}), 64'(e.v));
    end
  end

  initial begin
    HRST_N            = 1'b0;
    bus.HSEL_i        = '0;
    bus.HTRANS_i      = IDLE;
    bus.HRDATA_s_i    = '0;
    bus.HREADYOUT_s_i = 16'h7FFF;
    bus.HRESP_s_i     = 16'h8008;
    bus.HRDATA_s_i[32*1  +: 32] = 32'h1111_0001;
    bus.HRDATA_s_i[32*3  +: 32] = 32'h3333_0003;
    bus.HRDATA_s_i[32*15 +: 32] = 32'hFFFF_FFFF;

    repeat (2) next_cyc();
    chk("rst_bus", 64'({bus.HREADY_o, bus.HRESP_o, bus.HRDATA_o}), 64'({1'b1, 1'b0, 32'h0}));
    chk("rst_cnt", 64'(err_cnt), 64'd0);
    HRST_N = 1'b1;
    next_cyc();

    // Slot 2 read with two wait states
    drive(16'h0004, NONSEQ);
    push("t2_addr", 1'b1, 1'b0, 32'h0);
    push("t2_w1", 1'b0, 1'b0, 32'h0);
    push("t2_w2", 1'b0, 1'b0, 32'h0);
    push("t2_data", 1'b1, 1'b0, 32'hDEAD_BEEF);
    next_cyc();
    drive(16'h0000, IDLE);
    bus.HREADYOUT_s_i[2] = 1'b0;
    next_cyc();
    next_cyc();
    bus.HREADYOUT_s_i[2] = 1'b1;
    bus.HRDATA_s_i[32*2 +: 32] = 32'hDEAD_BEEF;
    next_cyc();

    // Unmapped NONSEQ to the dummy slot
    drive(16'h8000, NONSEQ);
    push("t3_addr", 1'b1, 1'b0, 32'h0);
    push("t3_err1", 1'b0, 1'b1, 32'h0);
    push("t3_err2", 1'b1, 1'b1, 32'h0);
    next_cyc();
    drive(16'h0000, IDLE);
    next_cyc();
    next_cyc();
    chk("t3_cnt", 64'(err_cnt), 64'd1);

    // IDLE to dummy is OKAY, then a back-to-back NONSEQ pair
    drive(16'h8000, IDLE);
    push("t4_idle_addr", 1'b1, 1'b0, 32'h0);
    push("t4_idle_dp", 1'b1, 1'b0, 32'h0);
    next_cyc();
    drive(16'h8000, NONSEQ);
    push("t4_err1a", 1'b0, 1'b1, 32'h0);
    push("t4_err2a", 1'b1, 1'b1, 32'h0);
    next_cyc();
    next_cyc();
    push("t4_err1b", 1'b0, 1'b1, 32'h0);
    push("t4_err2b", 1'b1, 1'b1, 32'h0);
    next_cyc();
    next_cyc();
    drive(16'h0000, IDLE);
    next_cyc();
    chk("t4_cnt", 64'(err_cnt), 64'd3);

    // HSEL all-zero behaves as unmapped; multi-hot picks the lowest slot
    drive(16'h0000, NONSEQ);
    push("t5_addr", 1'b1, 1'b0, 32'h0);
    push("t5_err1", 1'b0, 1'b1, 32'h0);
    push("t5_err2", 1'b1, 1'b1, 32'h0);
    next_cyc();
    next_cyc();
    drive(16'h0006, NONSEQ);
    bus.HRDATA_s_i[32*2 +: 32] = 32'h2222_0002;
    push("t5_slot1", 1'b1, 1'b0, 32'h1111_0001);
    next_cyc();
    drive(16'h0000, IDLE);
    next_cyc();
    chk("t5_cnt", 64'(err_cnt), 64'd4);

    // Real slave ERROR response is routed through unchanged
    drive(16'h0008, NONSEQ);
    push("t7_addr", 1'b1, 1'b0, 32'h0);
    push("t7_slot3", 1'b1, 1'b1, 32'h3333_0003);
    next_cyc();
    drive(16'h0000, IDLE);
    next_cyc();
    chk("t7_cnt", 64'(err_cnt), 64'd4);

    // Fifth dummy error: narrow counter saturates
    drive(16'h8000, NONSEQ);
    push("t6_addr", 1'b1, 1'b0, 32'h0);
    push("t6_err1", 1'b0, 1'b1, 32'h0);
    push("t6_err2", 1'b1, 1'b1, 32'h0);
    next_cyc();
    drive(16'h0000, IDLE);
    next_cyc();
    next_cyc();
    chk("t6_cnt16", 64'(err_cnt), 64'd5);
    chk("t6_cnt2_sat", 64'(err_cnt2), 64'd3);

    // Reset pulse while the dummy sits in ERR1
    drive(16'h8000, NONSEQ);
    push("t6r_addr", 1'b1, 1'b0, 32'h0);
    next_cyc();
    chk("t6r_err1", 64'({bus.HREADY_o, bus.HRESP_o}), 64'(2'b01));
    drive(16'h0000, IDLE);
    #1 HRST_N = 1'b0;
    #1;
    chk("t6r_bus", 64'({bus.HREADY_o, bus.HRESP_o, bus.HRDATA_o}), 64'({1'b1, 1'b0, 32'h0}));
    chk("t6r_cnt", 64'({err_cnt, err_cnt2}), 64'd0);
    @(negedge HCLK);
    #2 HRST_N = 1'b1;
    next_cyc();
    push("t6r_post", 1'b1, 1'b0, 32'h0);
    next_cyc();

    for (int i = 0; i < 10 && sb.size() > 0; i++) next_cyc();
    chk("sb_drain", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
